// File: rtl/div_arb_pkg.sv
// ============================================================================
// Module      : div_arb_pkg
// Description : Shared constants and state encoding for the div16_arbiter
//               slice (arbiter, round-robin picker and divider core).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_arb_pkg;

  // Operand / quotient width of the shared divider core.
  localparam int W = 16;

  // Cycles from an accepted request (IDLE) to its ack pulse (RESP).
  localparam int DIV_LAT = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div16_arbiter_core.sv
// ============================================================================
// Module      : div16_core
// Description : 16-bit unsigned iterative (restoring) divider, one quotient
//               bit per cycle. run low loads the operands and clears done;
//               run high iterates and then raises done, which stays high
//               until the next run-low restart. Divisor 0 yields 0xFFFF.
// Ports       : clock, reset - system clock, synchronous active-high reset
//               run          - low for a cycle restarts the core
//               num, den     - dividend / divisor, sampled while run is low
//               done         - quotient valid
//               ret          - quotient
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div16_core
  import div_arb_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         done,
  output logic [W-1:0] ret
);

  // Quotient bits are produced on run cycles 1..16; done is raised on run
  // cycle 19 so every job has the same fixed turnaround regardless of data.
  localparam logic [4:0] NUM_ITER = 5'd16;
  localparam logic [4:0] DONE_AT  = 5'd18;

  logic [4:0]   cnt;
  logic [W-1:0] rem;
  logic [W-1:0] quo;
  logic [W-1:0] dsr;
  logic [W:0]   sh;
  logic [W:0]   diff;
  logic         ge;

  always_comb begin
    sh   = {rem, quo[W-1]};
    ge   = (sh >= {1'b0, dsr});
    diff = sh - {1'b0, dsr};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
      done <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      rem  <= '0;
      quo  <= num;
      dsr  <= den;
      done <= 1'b0;
    end else if (!done) begin
      cnt <= cnt + 5'd1;
      if (cnt < NUM_ITER) begin
        if (ge) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= sh[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
      end
      if (cnt == DONE_AT) begin
        done <= 1'b1;
      end
    end
  end

  assign ret = quo;

endmodule

`default_nettype wire

// File: rtl/div16_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Selects the first set bit
//               of req at or after ptr, wrapping around NREQ.
// Ports       : req   - request vector
//               ptr   - priority pointer (index searched first)
//               gnt   - one-hot grant (all zero when nothing requested)
//               idx   - binary index of the granted requester
//               found - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            found
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Walk the requesters starting at ptr; the first hit wins.
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/div16_arbiter.sv
// ============================================================================
// Module      : div16_arbiter
// Description : Round-robin arbiter/sequencer sharing one 16-bit iterative
//               divider among NREQ requesters. A granted job is latched into
//               the divider operand registers, the core is restarted by a
//               one-cycle in_run low, and the quotient is returned with a
//               one-cycle ack to the granted requester.
// Ports       : clock, reset - system clock, synchronous active-high reset
//               in_req       - per-requester request level
//               in_num       - packed dividends, slice i = requester i
//               in_den       - packed divisors
//               out_gnt      - one-hot grant, held LOAD through RESP
//               out_ack      - one-hot single-cycle ack in RESP
//               out_result   - quotient, valid while out_ack != 0
//               out_busy     - high whenever the FSM is not IDLE
// Config      : DIV_ARB_SIGNED_EN - when defined, operands are treated as
//               two's complement (magnitudes divided, quotient sign fixed).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div16_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   in_req,
  input  logic [NREQ*W-1:0] in_num,
  input  logic [NREQ*W-1:0] in_den,
  output logic [NREQ-1:0]   out_gnt,
  output logic [NREQ-1:0]   out_ack,
  output logic [W-1:0]      out_result,
  output logic              out_busy
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   gidx, gidx_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [W-1:0]    result_nxt;
  logic            busy_nxt;
  logic            run, run_nxt;
  logic            first_wait, first_wait_nxt;
  logic [W-1:0]    div_num, div_num_nxt;
  logic [W-1:0]    div_den, div_den_nxt;
  logic            div_done;
  logic [W-1:0]    div_ret;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;

  logic [W-1:0]    num_arr [NREQ];
  logic [W-1:0]    den_arr [NREQ];
  logic [W-1:0]    sel_num, sel_den;
  logic [W-1:0]    op_num, op_den;
  logic [W-1:0]    ret_fix;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign num_arr[i] = in_num[i*W +: W];
    assign den_arr[i] = in_den[i*W +: W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (in_req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  div16_core u_core (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .ret   (div_ret)
  );

  assign sel_num = num_arr[pick_idx];
  assign sel_den = den_arr[pick_idx];

`ifdef DIV_ARB_SIGNED_EN
  // Divide magnitudes; the quotient sign is remembered from the operands.
  // -32768 negates to itself, which is 32768 read as unsigned.
  logic neg;

  assign op_num  = sel_num[W-1] ? -sel_num : sel_num;
  assign op_den  = sel_den[W-1] ? -sel_den : sel_den;
  assign ret_fix = neg ? -div_ret : div_ret;

  always_ff @(posedge clock) begin
    if (reset) begin
      neg <= 1'b0;
    end else if (state == IDLE && pick_found) begin
      neg <= sel_num[W-1] ^ sel_den[W-1];
    end
  end
`else
  assign op_num  = sel_num;
  assign op_den  = sel_den;
  assign ret_fix = div_ret;
`endif

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    gidx_nxt       = gidx;
    gnt_nxt        = out_gnt;
    ack_nxt        = '0;
    result_nxt     = out_result;
    run_nxt        = run;
    first_wait_nxt = 1'b0;
    div_num_nxt    = div_num;
    div_den_nxt    = div_den;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt   = LOAD;
          gidx_nxt    = pick_idx;
          gnt_nxt     = pick_gnt;
          div_num_nxt = op_num;
          div_den_nxt = op_den;
          run_nxt     = 1'b0;
        end
      end
      LOAD: begin
        state_nxt      = WAIT;
        run_nxt        = 1'b1;
        first_wait_nxt = 1'b1;
      end
      WAIT: begin
        // done may still reflect the previous job on the first WAIT cycle.
        if (!first_wait && div_done) begin
          state_nxt  = RESP;
          result_nxt = ret_fix;
          ack_nxt    = out_gnt;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        ptr_nxt   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      out_gnt    <= '0;
      out_ack    <= '0;
      out_result <= '0;
      out_busy   <= 1'b0;
      run        <= 1'b0;
      first_wait <= 1'b0;
      div_num    <= '0;
      div_den    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gidx       <= gidx_nxt;
      out_gnt    <= gnt_nxt;
      out_ack    <= ack_nxt;
      out_result <= result_nxt;
      out_busy   <= busy_nxt;
      run        <= run_nxt;
      first_wait <= first_wait_nxt;
      div_num    <= div_num_nxt;
      div_den    <= div_den_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div16_arbiter.sv
// ============================================================================
// Module      : tb_div16_arbiter
// Description : Directed self-checking bench for div16_arbiter (NREQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div16_arbiter;

  localparam int NREQ = 4;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   in_req;
  logic [NREQ*16-1:0] in_num;
  logic [NREQ*16-1:0] in_den;
  logic [NREQ-1:0]   out_gnt;
  logic [NREQ-1:0]   out_ack;
  logic [15:0]       out_result;
  logic              out_busy;

  int total = 0;
  int bad   = 0;

  div16_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_req     (in_req),
    .in_num     (in_num),
    .in_den     (in_den),
    .out_gnt    (out_gnt),
    .out_ack    (out_ack),
    .out_result (out_result),
    .out_busy   (out_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_op(input int i, input logic [15:0] n, input logic [15:0] d);
    in_num[i*16 +: 16] = n;
    in_den[i*16 +: 16] = d;
  endtask

  // Waits (bounded) for an ack and checks cycles elapsed, ack vector, result.
  task automatic expect_ack(input string tag, input int lat,
                            input logic [3:0] ack, input logic [15:0] res);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (out_ack == '0 && n < 100);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_ack"}, {28'd0, out_ack}, {28'd0, ack});
    chk({tag, "_res"}, {16'd0, out_result}, {16'd0, res});
  endtask

  initial begin
    reset  = 1'b1;
    in_req = '0;
    in_num = '0;
    in_den = '0;
    step(3);
    chk("rst_gnt",  {28'd0, out_gnt}, 32'd0);
    chk("rst_ack",  {28'd0, out_ack}, 32'd0);
    chk("rst_res",  {16'd0, out_result}, 32'd0);
    chk("rst_busy", {31'd0, out_busy}, 32'd0);
    reset = 1'b0;
    step(1);

    // Single requester 0: 20043 / 41 = 488, full latency profile.
    set_op(0, 16'd20043, 16'd41);
    in_req = 4'b0001;
    step(1);
    chk("t1_gnt_load", {28'd0, out_gnt}, 32'h1);
    chk("t1_busy",     {31'd0, out_busy}, 32'd1);
    step(20);
    chk("t1_ack_t21",  {28'd0, out_ack}, 32'd0);
    chk("t1_gnt_t21",  {28'd0, out_gnt}, 32'h1);
    step(1);
    chk("t1_ack_t22",  {28'd0, out_ack}, 32'h1);
    chk("t1_res",      {16'd0, out_result}, 32'd488);
    chk("t1_gnt_t22",  {28'd0, out_gnt}, 32'h1);
    in_req = '0;
    step(1);
    chk("t1_ack_off",  {28'd0, out_ack}, 32'd0);
    chk("t1_gnt_off",  {28'd0, out_gnt}, 32'd0);
    chk("t1_idle",     {31'd0, out_busy}, 32'd0);

    // Requester 2: 100 / 7 = 14, then divide by zero -> 0xFFFF.
    set_op(2, 16'd100, 16'd7);
    in_req = 4'b0100;
    expect_ack("r2_div7", 22, 4'b0100, 16'd14);
    in_req = '0;
    step(1);
    set_op(2, 16'd100, 16'd0);
    in_req = 4'b0100;
    expect_ack("r2_div0", 22, 4'b0100, 16'hFFFF);
    in_req = '0;
    step(1);

    // 0xFF9C / 7: unsigned 65436/7 = 9348; signed -100/7 = -14.
    set_op(3, 16'hFF9C, 16'd7);
    in_req = 4'b1000;
`ifdef DIV_ARB_SIGNED_EN
    expect_ack("r3_neg", 22, 4'b1000, 16'hFFF2);
    in_req = '0;
    step(1);
    set_op(3, 16'hFF9C, 16'hFFF9);
    in_req = 4'b1000;
    expect_ack("r3_negneg", 22, 4'b1000, 16'd14);
`else
    expect_ack("r3_uns", 22, 4'b1000, 16'd9348);
`endif
    in_req = '0;
    step(1);

    // All four at once: served 0,1,2,3 spaced 23 cycles apart.
    set_op(0, 16'd1000,  16'd10);
    set_op(1, 16'd30000, 16'd3);
    set_op(2, 16'd12345, 16'd111);
    set_op(3, 16'd9000,  16'd9);
    in_req = 4'b1111;
    expect_ack("all_0", 22, 4'b0001, 16'd100);
    in_req[0] = 1'b0;
    expect_ack("all_1", 23, 4'b0010, 16'd10000);
    in_req[1] = 1'b0;
    expect_ack("all_2", 23, 4'b0100, 16'd111);
    in_req[2] = 1'b0;
    expect_ack("all_3", 23, 4'b1000, 16'd1000);
    in_req[3] = 1'b0;
    step(1);
    // Pointer wrapped to 0 after serving 3.
    in_req = 4'b1001;
    expect_ack("wrap_0", 22, 4'b0001, 16'd100);
    in_req[0] = 1'b0;
    expect_ack("wrap_3", 23, 4'b1000, 16'd1000);
    in_req = '0;
    step(1);

    // Reset during WAIT aborts silently; held request is re-served.
    set_op(1, 16'd500, 16'd20);
    in_req = 4'b0010;
    step(10);
    chk("mid_gnt",  {28'd0, out_gnt}, 32'h2);
    chk("mid_busy", {31'd0, out_busy}, 32'd1);
    reset = 1'b1;
    step(1);
    chk("abort_gnt",  {28'd0, out_gnt}, 32'd0);
    chk("abort_ack",  {28'd0, out_ack}, 32'd0);
    chk("abort_res",  {16'd0, out_result}, 32'd0);
    chk("abort_busy", {31'd0, out_busy}, 32'd0);
    reset = 1'b0;
    expect_ack("reissue", 22, 4'b0010, 16'd25);
    in_req = '0;
    step(1);

    // Requester 1 holds across its ack while 2 is pending: 1, 2, then 1.
    set_op(2, 16'd100, 16'd7);
    in_req = 4'b0010;
    step(3);
    in_req = 4'b0110;
    expect_ack("hold_1a", 19, 4'b0010, 16'd25);
    expect_ack("hold_2",  23, 4'b0100, 16'd14);
    in_req[2] = 1'b0;
    expect_ack("hold_1b", 23, 4'b0010, 16'd25);
    in_req = '0;
    step(2);
    chk("end_busy", {31'd0, out_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
